mantissa_divider_24bit: RTL
===========================

# mantissa_divider_24bit

Iterative radix-2 restoring divider for normalized 24-bit mantissas (hidden bit included) in the FP ALU divide path. It computes the quotient directly from dividend and divisor with a valid/ready handshake. It is also the exact reference against which the reciprocal LUT seed and refinement path are checked. It returns a 25-bit quotient plus a sticky bit for the downstream rounding stage.

## Interface
Parameters:
- none (widths fixed by package constants MANT_W=24, QUOT_W=25)

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Asynchronous, active-high reset.
- valid_data_in  in  1  Operands valid; accepted when ready is also high.
- dividend  in  24  A, mantissa 1.23.
- divisor  in  24  B, mantissa 1.23; bit 23 must be 1 unless B == 0.
- ready  out  1  Block can accept operands this cycle.
- quotient  out  25  Q = floor(A·2^24 / B), format 1.24.
- sticky  out  1  Final remainder nonzero.
- div_by_zero  out  1  Result came from B == 0.
- valid_data_out  out  1  One-cycle pulse: quotient/sticky/div_by_zero valid.

## Operation
- FSM states, all transitions on rising clk:
  - IDLE: ready=1. On valid_data_in:
    - B == 0 → go to DONE with quotient=25'h1FFFFFF, sticky=0, div_by_zero=1.
    - otherwise load R=A (25 bits), D=B, count=24, Q=0, and go to DIVIDE.
  - DIVIDE: ready=0. Each cycle:
    - If R ≥ D: Q[count]=1 and R=R−D; else Q[count]=0.
    - Then R=R<<1.
    - When count==0, go to DONE; otherwise count−1.
  - DONE: ready=0, valid_data_out=1. Present quotient=Q, sticky=|R, div_by_zero=0. Next cycle go to IDLE.
- Width rules:
  - Invariant R < 2·D < 2^25, so R and the subtraction fit in 25 bits.
  - Q lies in [2^23, 2^25) for normalized A and B.
- Operands are sampled only at acceptance. Input changes during DIVIDE or DONE are ignored.
- valid_data_in while ready=0 is dropped, not queued. Upstream must hold the request until ready.
- Nonzero B with bit 23 = 0:
  - quotient value is unspecified;
  - handshake and latency are unchanged;
  - div_by_zero=0.
- quotient, sticky and div_by_zero hold their last value after DONE until the next DONE.

## Timing
- Reset values: state=IDLE, ready=1, valid_data_out=0, quotient=0, sticky=0, div_by_zero=0, internal R/D/Q/count=0.
- Acceptance at edge E0.
- Normal divide:
  - iterations occur at edges E1..E25;
  - DONE, with valid_data_out high, is the cycle after E25;
  - IDLE and ready=1 return after E26.
  - Throughput: one division per 27 cycles.
- Divide by zero: DONE is the cycle after E0 and ready=1 returns after E1.
- ready and valid_data_out are never high in the same cycle.
- Reset asserted in any state, including mid-DIVIDE: outputs return to reset values immediately (asynchronously). No valid_data_out pulse is produced for the aborted operation.

## Structure
- Shared package fp_alu_pkg holds:
  - MANT_W=24 and QUOT_W=25;
  - typedef enum logic[1:0] {IDLE, DIVIDE, DONE} div_state_t.
- Sub-module mantissa_div_step: combinational. Inputs R[24:0] and D[23:0]; outputs the quotient bit and next R (conditional subtract, then shift left 1). Instantiated once, one iteration per cycle.
- Remaining logic is in mantissa_divider_24bit: FSM, 5-bit counter, and operand/result registers.

## Test plan
- A=0x800000, B=0x800000 → after 26 cycles: quotient=0x1000000, sticky=0, div_by_zero=0.
- A=0x800000, B=0xC00000 → quotient=0xAAAAAA, sticky=1.
- A=0xFFFFFF, B=0x800000 → quotient=0x1FFFFFE, sticky=0. Also A=0xC00000, B=0x800000 → 0x1800000.
- B=0 with any A → valid_data_out in the cycle after acceptance; quotient=0x1FFFFFF, div_by_zero=1; ready high again one cycle later.
- Assert valid_data_in continuously with changing operands → only operands sampled while ready=1 are used, one result per 27 cycles. Check ready and valid_data_out are never high together.
- Assert rst at iteration 10 → ready=1 and all outputs 0 immediately with no pulse. A new A=B=0x800000 after release yields 0x1000000.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared constants and types for the FP ALU mantissa datapath.
package fp_alu_pkg;
  localparam int MANT_W = 24;  // mantissa incl. hidden bit, 1.23
  localparam int QUOT_W = 25;  // quotient 1.24, also partial-remainder width
  localparam int CNT_W  = 5;   // iteration counter, counts QUOT_W-1 .. 0

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} div_state_t;
endpackage

// File: rtl/mantissa_div_step.sv
// One restoring-division iteration: conditional subtract, then shift left.
module mantissa_div_step
  import fp_alu_pkg::*;
(
  input  logic [QUOT_W-1:0] i_r,
  input  logic [MANT_W-1:0] i_d,
  output logic              o_qbit,
  output logic [QUOT_W-1:0] o_r
);
  logic [QUOT_W-1:0] w_d_ext;
  logic [QUOT_W-1:0] w_diff;

  // R < 2D holds, so after subtraction R < D < 2^24 and the shift cannot overflow.
  always_comb begin
    w_d_ext = {1'b0, i_d};
    o_qbit  = (i_r >= w_d_ext);
    w_diff  = o_qbit ? (i_r - w_d_ext) : i_r;
    o_r     = w_diff << 1;
  end
endmodule

// File: rtl/mantissa_divider_24bit.sv
// Iterative radix-2 restoring divider: Q = floor(A*2^24/B), one bit per cycle.
module mantissa_divider_24bit
  import fp_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_data_in,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic              ready,
  output logic [QUOT_W-1:0] quotient,
  output logic              sticky,
  output logic              div_by_zero,
  output logic              valid_data_out
);
  div_state_t        r_state, w_state_nxt;
  logic [QUOT_W-1:0] r_r;
  logic [MANT_W-1:0] r_d;
  logic [QUOT_W-1:0] r_q;
  logic [CNT_W-1:0]  r_cnt;
  logic [QUOT_W-1:0] r_quot;
  logic              r_sticky;
  logic              r_dbz;

  logic              w_qbit;
  logic [QUOT_W-1:0] w_r_nxt;
  logic [QUOT_W-1:0] w_q_upd;
  logic              w_b_zero;

  mantissa_div_step u_step (
    .i_r    (r_r),
    .i_d    (r_d),
    .o_qbit (w_qbit),
    .o_r    (w_r_nxt)
  );

  // Quotient with this iteration's bit inserted at position r_cnt.
  always_comb begin
    w_q_upd  = r_q | ({{(QUOT_W-1){1'b0}}, w_qbit} << r_cnt);
    w_b_zero = (divisor == '0);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt    = r_state;
    ready          = 1'b0;
    valid_data_out = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (valid_data_in) w_state_nxt = w_b_zero ? DONE : DIVIDE;
      end
      DIVIDE: if (r_cnt == '0) w_state_nxt = DONE;
      DONE: begin
        valid_data_out = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration, and result registers (results hold until next DONE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r      <= '0;
      r_d      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_sticky <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (valid_data_in) begin
          if (w_b_zero) begin
            r_quot   <= '1;
            r_sticky <= 1'b0;
            r_dbz    <= 1'b1;
          end else begin
            r_r   <= {1'b0, dividend};
            r_d   <= divisor;
            r_q   <= '0;
            r_cnt <= CNT_W'(QUOT_W - 1);
          end
        end
        DIVIDE: begin
          r_r <= w_r_nxt;
          r_q <= w_q_upd;
          if (r_cnt == '0) begin
            r_quot   <= w_q_upd;
            r_sticky <= |w_r_nxt;
            r_dbz    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign sticky      = r_sticky;
  assign div_by_zero = r_dbz;
endmodule
